tt_regbank_port: RTL and testbench

Parametrised host-access register bank for the Tiny Tapeout user-project top level. An external host, such as the cocotb bench or a microcontroller on the demo board, issues strobe-framed commands over `ui_in` and `uio_in`. The block holds `NREG` byte registers for the design core and returns read data on `uio_out` under `uio_oe` control. It generalises the fixed pin wiring of the top-level harness with a synchronised handshake, a configurable register count, optional address auto-increment, and error reporting.

---
 rtl/tt_regbank_port.sv | 132 +++++++++++++
 tb/tb_tt_regbank_port.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tt_regbank_port.sv
// Host-access register bank for the Tiny Tapeout top level: strobe-framed
// SETADDR/WRITE/READ/NOP commands over ui_in/uio_in, read data on uio_out.
module tt_regbank_port #(
  parameter int NREG        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AUTOINC     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [7:0]        uo_out,
  output logic [NREG*8-1:0] regs_o
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [1:0] CMD_SETADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_READ    = 2'b10;
  localparam logic [6:0] NREG_W      = 7'(NREG);
  localparam logic [5:0] LAST_ADDR   = 6'(NREG - 1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [5:0]             addr_q;
  logic                   err_q;
  logic                   ack_q;
  logic [7:0]             rdata_q;
  logic [7:0]             regs_q [NREG];

  logic                   strobeSync;
  logic                   strobeRise;
  logic [1:0]             cmd;
  logic                   addrLegal;
  logic                   newAddrLegal;
  logic [5:0]             addrInc_d;
  logic [7:0]             rdSel;
  logic                   unused_ok;

  assign unused_ok = ^ui_in[4:0];

  // Strobe synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[7]};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobeSync   = sync_q[SYNC_STAGES-1];
  assign strobeRise   = strobeSync & ~hist_q;
  assign cmd          = ui_in[6:5];
  assign addrLegal    = {1'b0, addr_q} < NREG_W;
  assign newAddrLegal = {1'b0, uio_in[5:0]} < NREG_W;

  // An out-of-range address never advances, so the error stays visible.
  always_comb begin
    addrInc_d = addr_q;
    if (AUTOINC != 0 && addrLegal) begin
      addrInc_d = (addr_q == LAST_ADDR) ? 6'd0 : addr_q + 6'd1;
    end
  end

  always_comb begin
    rdSel = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (addr_q == 6'(i)) rdSel = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 6'd0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (strobeRise && ena) begin
            ack_q <= ~ack_q;
            unique case (cmd)
              CMD_SETADDR: begin
                addr_q <= uio_in[5:0];
                err_q  <= ~newAddrLegal;
              end
              CMD_WRITE: begin
                if (!addrLegal) err_q <= 1'b1;
                for (int i = 0; i < NREG; i++) begin
                  if (addr_q == 6'(i)) regs_q[i] <= uio_in;
                end
                addr_q <= addrInc_d;
              end
              CMD_READ: begin
                if (!addrLegal) err_q <= 1'b1;
                rdata_q <= rdSel;
                addr_q  <= addrInc_d;
                state_q <= DRIVE;
              end
              default: ;
            endcase
          end
        end
        DRIVE: begin
          if (!strobeSync) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output enables decode straight from state so reset releases them at once.
  assign uio_oe  = (state_q == DRIVE) ? 8'hFF : 8'h00;
  assign uio_out = (state_q == DRIVE) ? rdata_q : 8'h00;
  assign uo_out  = {ack_q, err_q, addr_q};

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NREG; i++) regs_o[8*i +: 8] = regs_q[i];
  end

endmodule

// File: tb/tb_tt_regbank_port.sv
// Self-checking bench for tt_regbank_port: transaction-level model compared
// every cycle, plus directed literal checks and randomized command traffic.
module tb_tt_regbank_port;

  localparam int NREG    = 8;
  localparam int SYNC    = 2;
  localparam int AUTOINC = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [7:0]        ui_in;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [7:0]        uo_out;
  logic [NREG*8-1:0] regs_o;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  logic [7:0] mRegs [NREG];
  logic [5:0] mAddr;
  logic       mErr, mAck, mDrive;
  logic [7:0] mRdata;

  tt_regbank_port #(.NREG(NREG), .SYNC_STAGES(SYNC), .AUTOINC(AUTOINC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out), .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void resetModel();
    for (int i = 0; i < NREG; i++) mRegs[i] = 8'h00;
    mAddr = 6'd0; mErr = 1'b0; mAck = 1'b0; mDrive = 1'b0; mRdata = 8'h00;
  endfunction

  function automatic void advance();
    if (AUTOINC != 0 && int'(mAddr) < NREG) mAddr = 6'((int'(mAddr) + 1) % NREG);
  endfunction

  function automatic void modelExec(input logic [1:0] cmd, input logic [7:0] data, input logic en);
    if (!en) return;
    mAck = ~mAck;
    case (cmd)
      2'b00: begin mAddr = data[5:0]; mErr = (int'(data[5:0]) >= NREG); end
      2'b01: begin
        if (int'(mAddr) < NREG) mRegs[mAddr] = data; else mErr = 1'b1;
        advance();
      end
      2'b10: begin
        if (int'(mAddr) < NREG) mRdata = mRegs[mAddr];
        else begin mRdata = 8'h00; mErr = 1'b1; end
        advance();
        mDrive = 1'b1;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [NREG*8-1:0] expRegs();
    logic [NREG*8-1:0] r;
    for (int i = 0; i < NREG; i++) r[8*i +: 8] = mRegs[i];
    return r;
  endfunction

  // Every cycle the model is authoritative for all outputs, including latency.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_uo_out", 64'(uo_out), 64'({mAck, mErr, mAddr}));
      checkOutput("cyc_uio_oe", 64'(uio_oe), mDrive ? 64'hFF : 64'h00);
      checkOutput("cyc_uio_out", 64'(uio_out), mDrive ? 64'(mRdata) : 64'h00);
      checkOutput("cyc_regs_o", 64'(regs_o), 64'(expRegs()));
    end
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobeUp(input logic [1:0] cmd, input logic [7:0] data, input logic en);
    ui_in  = {1'b1, cmd, 5'($urandom)};
    uio_in = data;
    ena    = en;
    repeat (SYNC + 1) @(posedge clk);
    #1 modelExec(cmd, data, en);
  endtask

  task automatic strobeDown();
    ui_in[7] = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1 mDrive = 1'b0;
    uio_in = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data, input logic en,
                               input int hi, input int lo);
    strobeUp(cmd, data, en);
    waitCycles(hi - SYNC - 1);
    strobeDown();
    waitCycles(lo - SYNC - 1);
  endtask

  initial begin
    resetModel();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    waitCycles(3);
    cmpEn = 1'b1;
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("reset_uo_out", 64'(uo_out), 64'h00);
    checkOutput("reset_uio_oe", 64'(uio_oe), 64'h00);
    checkOutput("reset_regs_o", 64'(regs_o), 64'h0);

    applyStimulus(2'b00, 8'h03, 1'b1, 4, 4);
    applyStimulus(2'b01, 8'hA5, 1'b1, 4, 4);
    checkOutput("write_reg3", 64'(regs_o[31:24]), 64'hA5);
    checkOutput("write_uo_out", 64'(uo_out), 64'h04);

    applyStimulus(2'b00, 8'h03, 1'b1, 4, 4);
    strobeUp(2'b10, 8'h00, 1'b1);
    checkOutput("read_oe", 64'(uio_oe), 64'hFF);
    checkOutput("read_data", 64'(uio_out), 64'hA5);
    checkOutput("read_addr", 64'(uo_out[5:0]), 64'h04);
    waitCycles(2);
    strobeDown();
    checkOutput("read_release", 64'(uio_oe), 64'h00);
    waitCycles(2);

    applyStimulus(2'b00, 8'h07, 1'b1, 3, 3);
    applyStimulus(2'b01, 8'h11, 1'b1, 3, 3);
    applyStimulus(2'b01, 8'h22, 1'b1, 3, 3);
    checkOutput("wrap_reg7", 64'(regs_o[63:56]), 64'h11);
    checkOutput("wrap_reg0", 64'(regs_o[7:0]), 64'h22);
    checkOutput("wrap_uo_out", 64'(uo_out), 64'h81);

    applyStimulus(2'b00, 8'h09, 1'b1, 4, 4);
    checkOutput("bad_setaddr_uo", 64'(uo_out), 64'h49);
    applyStimulus(2'b01, 8'hFF, 1'b1, 4, 4);
    checkOutput("bad_write_uo", 64'(uo_out), 64'hC9);
    checkOutput("bad_write_regs", 64'(regs_o), 64'h1100_0000_A500_0022);
    applyStimulus(2'b00, 8'h02, 1'b1, 4, 4);
    checkOutput("err_clear_uo", 64'(uo_out), 64'h02);

    // A rise seen while disabled is consumed; enabling mid-pulse must not replay it.
    ena = 1'b0; ui_in = 8'b1010_0000; uio_in = 8'h5A;
    waitCycles(SYNC + 2);
    ena = 1'b1;
    waitCycles(3);
    ui_in[7] = 1'b0;
    waitCycles(SYNC + 2);
    checkOutput("ena_uo_out", 64'(uo_out), 64'h02);
    checkOutput("ena_regs", 64'(regs_o), 64'h1100_0000_A500_0022);

    for (int n = 0; n < 300; n++) begin
      logic [1:0] c;
      logic [7:0] d;
      c = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (c == 2'b00) d = {d[7:6], 6'($urandom_range(0, NREG + 3))};
      applyStimulus(c, d, ($urandom_range(0, 4) != 0), $urandom_range(3, 5), $urandom_range(3, 5));
    end

    applyStimulus(2'b00, 8'h03, 1'b1, 4, 4);
    strobeUp(2'b10, 8'h00, 1'b1);
    checkOutput("pre_reset_oe", 64'(uio_oe), 64'hFF);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_oe", 64'(uio_oe), 64'h00);
    resetModel();
    ui_in = 8'h00;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("post_reset_uo", 64'(uo_out), 64'h00);
    checkOutput("post_reset_regs", 64'(regs_o), 64'h0);
    checkOutput("post_reset_out", 64'(uio_out), 64'h00);

    cmpEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
